// File: rtl/ext_pkg.sv
// Immediate-extension modes and the width-generic extension function shared by the pipe and its users.
// Combinational only; no latency, no flow control.
package ext_pkg;

  typedef enum logic [1:0] {
    SIGN   = 2'd0,
    ZERO   = 2'd1,
    UPPER  = 2'd2,
    BRANCH = 2'd3
  } ext_mode_t;

  localparam int EXT_MAX_W = 64;
  typedef logic [EXT_MAX_W-1:0] ext_word_t;

  // imm is zero-padded to EXT_MAX_W; in_w/out_w select the real widths (in_w <= out_w <= EXT_MAX_W).
  function automatic ext_word_t ext_compute(ext_word_t imm, ext_mode_t mode, int in_w, int out_w);
    ext_word_t mask_in;
    ext_word_t mask_out;
    ext_word_t lo;
    ext_word_t sext;
    ext_word_t res;
    logic      sign;
    mask_in  = (ext_word_t'(1) << in_w) - ext_word_t'(1);
    mask_out = (ext_word_t'(1) << out_w) - ext_word_t'(1);
    lo       = imm & mask_in;
    sign     = |(lo & (ext_word_t'(1) << (in_w - 1)));
    sext     = sign ? (lo | ~mask_in) : lo;
    res      = '0;
    case (mode)
      SIGN:    res = sext;
      ZERO:    res = lo;
      UPPER:   res = lo << (out_w - in_w);
      BRANCH:  res = sext << 2;
      default: res = '0;
    endcase
    return res & mask_out;
  endfunction

endpackage

// File: rtl/skid_buf.sv
// Two-entry valid/ready skid buffer; 1-cycle latency, full throughput.
// in_ready is registered (state != FULL) and never looks at out_ready; head holds while stalled.
module skid_buf #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q;
  logic         push;
  logic         pop;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = head_q;
  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = in_data;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (push && pop) begin
          head_d = in_data;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain side can move.
        if (pop) begin
          state_d = ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != FULL);
    end
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Extends an IN_W immediate to OUT_W by mode, registered once through a skid buffer.
// 1-cycle latency, full throughput; in_ready is registered and independent of out_ready.
module imm_extend_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  ext_mode_t        in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output ext_mode_t        out_mode
);

  logic [OUT_W-1:0] ext_data;
  logic [OUT_W+1:0] out_pay;

  assign ext_data = OUT_W'(ext_compute(ext_word_t'(in_imm), in_mode, IN_W, OUT_W));

  skid_buf #(
    .W(OUT_W + 2)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  ({in_mode, ext_data}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_pay)
  );

  assign out_data = out_pay[OUT_W-1:0];
  assign out_mode = ext_mode_t'(out_pay[OUT_W+1:OUT_W]);

endmodule
